cavlc_read_run_befores: RTL

Sequential stage directly downstream of the total_zeros decoder in the CAVLC residual path. Takes TotalCoeff, TotalZeros (as initial ZeroLeft) and the already-decoded level array, and decodes one run_before codeword per cycle from the bitstream window. It places each level at its scan position in a 16-entry coefficient register file. It also reports consumed bit length to the bitstream shifter each cycle and signals completion to the residual controller.

---
 rtl/cavlc_read_run_befores_pkg.sv | 14 +
 rtl/cavlc_read_run_befores_vlc.sv | 87 ++++++++
 rtl/cavlc_read_run_befores.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cavlc_read_run_befores_pkg.sv
// Shared constants and state encoding for the CAVLC run_before placement stage.
package cavlc_read_run_befores_pkg;

  localparam int LEVEL_W_DEF = 9;
  localparam int RB_MAX_LEN  = 11;
  localparam int MAX_COEFF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cavlc_read_run_befores_vlc.sv
// Combinational run_before codeword decoder (H.264 Table 9-10), zl saturated at 7.
module cavlc_run_before_vlc (
  input  logic [0:10] rbsp,
  input  logic [2:0]  zl,
  output logic [3:0]  run,
  output logic [3:0]  len
);

  always_comb begin
    run = 4'd0;
    len = 4'd0;
    case (zl)
      3'd0: begin
        run = 4'd0;
        len = 4'd0;
      end
      3'd1: begin
        run = rbsp[0] ? 4'd0 : 4'd1;
        len = 4'd1;
      end
      3'd2: begin
        if (rbsp[0]) begin
          run = 4'd0;
          len = 4'd1;
        end else begin
          run = rbsp[1] ? 4'd1 : 4'd2;
          len = 4'd2;
        end
      end
      3'd3: begin
        run = 4'd3 - {2'b00, rbsp[0:1]};
        len = 4'd2;
      end
      3'd4: begin
        if (rbsp[0] | rbsp[1]) begin
          run = 4'd3 - {2'b00, rbsp[0:1]};
          len = 4'd2;
        end else begin
          run = rbsp[2] ? 4'd3 : 4'd4;
          len = 4'd3;
        end
      end
      3'd5: begin
        if (rbsp[0]) begin
          run = rbsp[1] ? 4'd0 : 4'd1;
          len = 4'd2;
        end else begin
          run = 4'd5 - {2'b00, rbsp[1:2]};
          len = 4'd3;
        end
      end
      3'd6: begin
        if (rbsp[0] & rbsp[1]) begin
          run = 4'd0;
          len = 4'd2;
        end else begin
          len = 4'd3;
          case (rbsp[0:2])
            3'b000:  run = 4'd1;
            3'b001:  run = 4'd2;
            3'b011:  run = 4'd3;
            3'b010:  run = 4'd4;
            3'b101:  run = 4'd5;
            default: run = 4'd6;
          endcase
        end
      end
      default: begin
        if (|rbsp[0:2]) begin
          run = 4'd7 - {1'b0, rbsp[0:2]};
          len = 4'd3;
        end else begin
          // No terminating one in the window: report an out-of-range run so it clamps and flags.
          run = 4'd15;
          len = 4'd11;
          for (int k = 10; k >= 3; k--) begin
            if (rbsp[k]) begin
              run = 4'(k + 4);
              len = 4'(k + 1);
            end
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/cavlc_read_run_befores.sv
// CAVLC run_before stage: places latched levels into scan positions, one per cycle.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one coefficient written per ena cycle, run_before decoded
//   DONE  | one-cycle done/err pulse, coeffs final
module cavlc_read_run_befores
  import cavlc_read_run_befores_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         ena,
  input  logic [0:RB_MAX_LEN-1]        rbsp,
  input  logic [4:0]                   TotalCoeff,
  input  logic [3:0]                   TotalZeros,
  input  logic [MAX_COEFF*LEVEL_W-1:0] levels,
  output logic [3:0]                   len_comb,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [MAX_COEFF*LEVEL_W-1:0] coeffs
);

  state_e             state_q;
  logic               busy_q, done_q, err_o_q, err_q;
  logic [4:0]         i_q, pos_q, tc_q;
  logic [3:0]         zl_q;
  logic [LEVEL_W-1:0] lvl_q   [MAX_COEFF];
  logic [LEVEL_W-1:0] coeff_q [MAX_COEFF];

  logic [2:0] zl_sat;
  logic [3:0] vlc_run, vlc_len, run_raw, run_eff, zl_d;
  logic [4:0] pos_d;
  logic       read_en, last, over, err_d;

  cavlc_run_before_vlc u_vlc (
    .rbsp (rbsp),
    .zl   (zl_sat),
    .run  (vlc_run),
    .len  (vlc_len)
  );

  always_comb begin
    zl_sat   = (zl_q > 4'd7) ? 3'd7 : zl_q[2:0];
    last     = (i_q == (tc_q - 5'd1));
    read_en  = (state_q == ST_RUN) && ena && !last && (zl_q != 4'd0);
    len_comb = read_en ? vlc_len : 4'd0;
    run_raw  = read_en ? vlc_run : 4'd0;
    over     = (run_raw > zl_q);
    run_eff  = over ? zl_q : run_raw;
    err_d    = err_q | over;
    pos_d    = pos_q - 5'd1 - {1'b0, run_eff};
    zl_d     = zl_q - run_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_o_q <= 1'b0;
      err_q   <= 1'b0;
      i_q     <= 5'd0;
      pos_q   <= 5'd0;
      tc_q    <= 5'd0;
      zl_q    <= 4'd0;
      for (int k = 0; k < MAX_COEFF; k++) begin
        lvl_q[k]   <= '0;
        coeff_q[k] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q  <= 1'b0;
          err_o_q <= 1'b0;
          if (start) begin
            for (int k = 0; k < MAX_COEFF; k++) begin
              lvl_q[k]   <= levels[k*LEVEL_W +: LEVEL_W];
              coeff_q[k] <= '0;
            end
            tc_q  <= TotalCoeff;
            i_q   <= 5'd0;
            pos_q <= TotalCoeff + {1'b0, TotalZeros} - 5'd1;
            zl_q  <= TotalZeros;
            err_q <= 1'b0;
            if (TotalCoeff == 5'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (ena) begin
            coeff_q[pos_q[3:0]] <= lvl_q[i_q[3:0]];
            pos_q <= pos_d;
            zl_q  <= zl_d;
            i_q   <= i_q + 5'd1;
            err_q <= err_d;
            if (last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_o_q <= err_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          err_o_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_o_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_o_q;

  for (genvar g = 0; g < MAX_COEFF; g++) begin : g_pack
    assign coeffs[g*LEVEL_W +: LEVEL_W] = coeff_q[g];
  end

endmodule
